// File: rtl/conv_pkg.sv
// Shared constants and types for the 4x4 FP16 convolution datapath.
package conv_pkg;
    localparam int DATA_WIDTH  = 16;
    localparam int KERNEL_SIZE = 4;

    typedef logic [15:0] fp16_t;

    typedef enum logic [1:0] {
        IDLE        = 2'd0,
        LOAD_KERNEL = 2'd1,
        STREAM      = 2'd2,
        DRAIN       = 2'd3
    } feeder_state_t;
endpackage

// File: rtl/conv4_line_buffer.sv
// Per-column history of the previous ROWS image rows; read is combinational,
// the shifted-in update lands on the clock edge so a same-cycle read sees old data.
module conv4_line_buffer
    import conv_pkg::*;
#(
    parameter  int DEPTH = 28,
    parameter  int ROWS  = KERNEL_SIZE - 1,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       we_i,
    input  logic [AW-1:0]              addr_i,
    input  logic [DATA_WIDTH-1:0]      pix_i,
    output logic [ROWS*DATA_WIDTH-1:0] col_o
);
    // MSB slice holds the oldest row; new pixel enters at the LSB slice.
    logic [ROWS*DATA_WIDTH-1:0] mem_q [DEPTH];

    assign col_o = mem_q[addr_i];

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[addr_i] <= {col_o[(ROWS-1)*DATA_WIDTH-1:0], pix_i};
        end
    end
endmodule

// File: rtl/conv4_window_feeder.sv
// Kernel loader and raster-to-column sequencer in front of the 4x4 conv engine.
// state       | meaning
// IDLE        | waiting for start
// LOAD_KERNEL | accepting 16 column-major kernel elements
// STREAM      | accepting pixels, emitting columns once 3 rows are buffered
// DRAIN       | 3 cycles flushing the valid_out pipe, done in the last one
module conv4_window_feeder
    import conv_pkg::*;
#(
    parameter int IMG_WIDTH  = 28,
    parameter int IMG_HEIGHT = 28
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic                          k_valid,
    input  logic [DATA_WIDTH-1:0]         k_data,
    output logic                          k_ready,
    input  logic                          pix_valid,
    input  logic [DATA_WIDTH-1:0]         pix_data,
    output logic                          pix_ready,
    output logic [DATA_WIDTH-1:0]         data_out0,
    output logic [DATA_WIDTH-1:0]         data_out1,
    output logic [DATA_WIDTH-1:0]         data_out2,
    output logic [DATA_WIDTH-1:0]         data_out3,
    output logic                          kernel_load,
    output logic                          valid_in,
    output logic                          valid_out,
    output logic [$clog2(IMG_HEIGHT)-1:0] out_row,
    output logic [$clog2(IMG_WIDTH)-1:0]  out_col,
    output logic                          busy,
    output logic                          done
);
    localparam int CW      = $clog2(IMG_WIDTH);
    localparam int RW      = $clog2(IMG_HEIGHT);
    localparam int KW      = $clog2(KERNEL_SIZE*KERNEL_SIZE);
    localparam int LB_ROWS = KERNEL_SIZE - 1;
    localparam int DW      = DATA_WIDTH;

    localparam logic [CW-1:0] COL_LAST  = CW'(IMG_WIDTH-1);
    localparam logic [RW-1:0] ROW_LAST  = RW'(IMG_HEIGHT-1);
    localparam logic [CW-1:0] COL_WIN   = CW'(KERNEL_SIZE-1);
    localparam logic [RW-1:0] ROW_EMIT  = RW'(KERNEL_SIZE-1);
    localparam logic [KW-1:0] K_LAST    = KW'(KERNEL_SIZE*KERNEL_SIZE-1);

    feeder_state_t state_q, state_d;
    logic [KW-1:0]                 k_cnt_q, k_cnt_d;
    logic [LB_ROWS-1:0][DW-1:0]    kcol_q, kcol_d;
    logic [CW-1:0]                 col_q, col_d;
    logic [RW-1:0]                 row_q, row_d;
    logic [1:0]                    drain_q, drain_d;
    logic [KERNEL_SIZE*DW-1:0]     data_q, data_d;
    logic                          kload_q, kload_d;
    logic                          vin_q, vin_d;
    logic                          win_q, win_d;
    logic [RW-1:0]                 win_row_q, win_row_d;
    logic [CW-1:0]                 win_col_q, win_col_d;
    logic                          pipe_q;
    logic [RW-1:0]                 pipe_row_q;
    logic [CW-1:0]                 pipe_col_q;
    logic                          vout_q;
    logic [RW-1:0]                 out_row_q;
    logic [CW-1:0]                 out_col_q;
    logic                          done_q, done_d;

    logic                          lb_we;
    logic [LB_ROWS*DW-1:0]         lb_col;

    assign k_ready   = (state_q == LOAD_KERNEL);
    assign pix_ready = (state_q == STREAM);
    assign busy      = (state_q != IDLE);
    assign lb_we     = pix_ready && pix_valid;

    conv4_line_buffer #(
        .DEPTH (IMG_WIDTH),
        .ROWS  (LB_ROWS)
    ) u_lb (
        .clk    (clk),
        .we_i   (lb_we),
        .addr_i (col_q),
        .pix_i  (pix_data),
        .col_o  (lb_col)
    );

    always_comb begin
        state_d   = state_q;
        k_cnt_d   = k_cnt_q;
        kcol_d    = kcol_q;
        col_d     = col_q;
        row_d     = row_q;
        drain_d   = drain_q;
        data_d    = data_q;
        kload_d   = 1'b0;
        vin_d     = 1'b0;
        win_d     = 1'b0;
        win_row_d = win_row_q;
        win_col_d = win_col_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = LOAD_KERNEL;
                    k_cnt_d = '0;
                    col_d   = '0;
                    row_d   = '0;
                    drain_d = '0;
                end
            end
            LOAD_KERNEL: begin
                if (k_valid) begin
                    k_cnt_d = k_cnt_q + 1'b1;
                    if (k_cnt_q[1:0] == 2'd3) begin
                        data_d  = {kcol_q[0], kcol_q[1], kcol_q[2], k_data};
                        kload_d = 1'b1;
                        vin_d   = 1'b1;
                    end else begin
                        kcol_d[k_cnt_q[1:0]] = k_data;
                    end
                    if (k_cnt_q == K_LAST) begin
                        state_d = STREAM;
                    end
                end
            end
            STREAM: begin
                if (pix_valid) begin
                    if (row_q >= ROW_EMIT) begin
                        data_d = {lb_col, pix_data};
                        vin_d  = 1'b1;
                        if (col_q >= COL_WIN) begin
                            win_d     = 1'b1;
                            win_row_d = row_q - ROW_EMIT;
                            win_col_d = col_q - COL_WIN;
                        end
                    end
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) begin
                            state_d = DRAIN;
                        end else begin
                            row_d = row_q + 1'b1;
                        end
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            DRAIN: begin
                drain_d = drain_q + 1'b1;
                done_d  = (drain_q == 2'd1);
                if (drain_q == 2'd2) begin
                    state_d = IDLE;
                    drain_d = '0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // win/pipe/vout form the two-cycle gap between shift and capture in the engine.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            k_cnt_q    <= '0;
            kcol_q     <= '0;
            col_q      <= '0;
            row_q      <= '0;
            drain_q    <= '0;
            data_q     <= '0;
            kload_q    <= 1'b0;
            vin_q      <= 1'b0;
            win_q      <= 1'b0;
            win_row_q  <= '0;
            win_col_q  <= '0;
            pipe_q     <= 1'b0;
            pipe_row_q <= '0;
            pipe_col_q <= '0;
            vout_q     <= 1'b0;
            out_row_q  <= '0;
            out_col_q  <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            k_cnt_q    <= k_cnt_d;
            kcol_q     <= kcol_d;
            col_q      <= col_d;
            row_q      <= row_d;
            drain_q    <= drain_d;
            data_q     <= data_d;
            kload_q    <= kload_d;
            vin_q      <= vin_d;
            win_q      <= win_d;
            win_row_q  <= win_row_d;
            win_col_q  <= win_col_d;
            pipe_q     <= win_q;
            pipe_row_q <= win_row_q;
            pipe_col_q <= win_col_q;
            vout_q     <= pipe_q;
            out_row_q  <= pipe_row_q;
            out_col_q  <= pipe_col_q;
            done_q     <= done_d;
        end
    end

    assign data_out0   = data_q[4*DW-1 -: DW];
    assign data_out1   = data_q[3*DW-1 -: DW];
    assign data_out2   = data_q[2*DW-1 -: DW];
    assign data_out3   = data_q[DW-1 -: DW];
    assign kernel_load = kload_q;
    assign valid_in    = vin_q;
    assign valid_out   = vout_q;
    assign out_row     = out_row_q;
    assign out_col     = out_col_q;
    assign done        = done_q;
endmodule

// File: tb/tb_conv4_window_feeder.sv
// Scoreboard bench for conv4_window_feeder on a 6x6 image with randomized gaps and data.
module tb_conv4_window_feeder;
    localparam int W = 6;
    localparam int H = 6;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        k_valid;
    logic [15:0] k_data;
    logic        k_ready;
    logic        pix_valid;
    logic [15:0] pix_data;
    logic        pix_ready;
    logic [15:0] data_out0, data_out1, data_out2, data_out3;
    logic        kernel_load, valid_in, valid_out;
    logic [2:0]  out_row, out_col;
    logic        busy, done;

    conv4_window_feeder #(.IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
        .clk(clk), .rst(rst), .start(start),
        .k_valid(k_valid), .k_data(k_data), .k_ready(k_ready),
        .pix_valid(pix_valid), .pix_data(pix_data), .pix_ready(pix_ready),
        .data_out0(data_out0), .data_out1(data_out1),
        .data_out2(data_out2), .data_out3(data_out3),
        .kernel_load(kernel_load), .valid_in(valid_in), .valid_out(valid_out),
        .out_row(out_row), .out_col(out_col), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    typedef struct packed { logic kl; logic win; logic [63:0] d; } vin_t;
    typedef struct packed { logic [2:0] row; logic [2:0] col; } vout_t;

    vin_t    vin_exp[$];
    vout_t   vout_exp[$];
    longint  due_q[$];

    int      checks = 0;
    int      failures = 0;
    longint  cyc = 0;
    int      done_cnt = 0;
    int      vout_seen = 0;
    int      vout_in_load = 0;

    function automatic void chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h expected=%h", nm, got, exp);
        end
    endfunction

    function automatic void fail(input string nm, input longint info);
        checks++;
        failures++;
        $display("FAIL %s at cycle %0d (info=%0d)", nm, cyc, info);
    endfunction

    vin_t   m_e;
    vout_t  m_o;
    longint m_t;

    always @(negedge clk) begin
        cyc++;
        if (!rst) begin
            if (valid_in) begin
                if (vin_exp.size() == 0) begin
                    fail("vin_unexpected", {data_out0, data_out1, data_out2, data_out3});
                end else begin
                    m_e = vin_exp.pop_front();
                    chk("kernel_load", kernel_load, m_e.kl);
                    chk("vin_data", {data_out0, data_out1, data_out2, data_out3}, m_e.d);
                    if (m_e.win) due_q.push_back(cyc + 2);
                end
            end
            if (valid_out) begin
                vout_seen++;
                if (k_ready) vout_in_load++;
                if (vout_exp.size() == 0 || due_q.size() == 0) begin
                    fail("vout_unexpected", {out_row, out_col});
                end else begin
                    m_o = vout_exp.pop_front();
                    m_t = due_q.pop_front();
                    chk("vout_timing", cyc, m_t);
                    chk("out_row", out_row, m_o.row);
                    chk("out_col", out_col, m_o.col);
                end
            end else if (due_q.size() > 0 && due_q[0] <= cyc) begin
                m_t = due_q.pop_front();
                fail("vout_missing", m_t);
            end
            if (done) begin
                done_cnt++;
                chk("done_vin_drained", vin_exp.size(), 0);
                chk("done_vout_drained", vout_exp.size(), 0);
            end
        end
    end

    task automatic push_k(input logic [15:0] d);
        int n = 0;
        k_valid = 1'b1;
        k_data  = d;
        while (!k_ready && n < 100) begin @(negedge clk); n++; end
        if (!k_ready) fail("k_ready_timeout", n);
        @(negedge clk);
        k_valid = 1'b0;
    endtask

    task automatic push_p(input logic [15:0] d);
        int n = 0;
        pix_valid = 1'b1;
        pix_data  = d;
        while (!pix_ready && n < 100) begin @(negedge clk); n++; end
        if (!pix_ready) fail("pix_ready_timeout", n);
        @(negedge clk);
        pix_valid = 1'b0;
    endtask

    task automatic gap(input int pct);
        int n = 0;
        while (n < 8 && $urandom_range(99) < pct) begin @(negedge clk); n++; end
    endtask

    // Expected stream derived directly from the windowing rules on whole arrays.
    task automatic run_frame(input bit rnd, input int gap_pct, input int start_at,
                             input bit khold, input int abort_at);
        logic [15:0] img [H][W];
        logic [15:0] kern [16];
        int d0, v0, vl0, offers, hits, n;
        for (int i = 0; i < 16; i++) kern[i] = rnd ? 16'($urandom) : 16'(16'h3C00 + i);
        for (int r = 0; r < H; r++)
            for (int c = 0; c < W; c++)
                img[r][c] = rnd ? 16'($urandom) : 16'((r << 8) | c);
        for (int j = 0; j < 4; j++)
            vin_exp.push_back('{1'b1, 1'b0, {kern[4*j], kern[4*j+1], kern[4*j+2], kern[4*j+3]}});
        for (int r = 3; r < H; r++)
            for (int c = 0; c < W; c++) begin
                vin_exp.push_back('{1'b0, (c >= 3), {img[r-3][c], img[r-2][c], img[r-1][c], img[r][c]}});
                if (c >= 3) vout_exp.push_back('{3'(r-3), 3'(c-3)});
            end
        d0 = done_cnt; v0 = vout_seen; vl0 = vout_in_load; offers = 0; hits = 0;

        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 16; i++) begin gap(gap_pct); push_k(kern[i]); end
        chk("vout_in_load", vout_in_load - vl0, 0);

        if (khold) begin k_valid = 1'b1; k_data = 16'hBEEF; end
        for (int p = 0; p < W*H; p++) begin
            if (p == abort_at) begin
                rst = 1'b1;
                @(negedge clk);
                chk("rst_outputs", {data_out0, data_out1, data_out2, data_out3, kernel_load,
                                    valid_in, valid_out, done}, '0);
                chk("rst_coords", {out_row, out_col}, '0);
                chk("rst_busy", busy, 0);
                vin_exp.delete(); vout_exp.delete(); due_q.delete();
                pix_valid = 1'b0; k_valid = 1'b0;
                @(negedge clk);
                vin_exp.delete(); vout_exp.delete(); due_q.delete();
                rst = 1'b0;
                @(negedge clk);
                return;
            end
            gap(gap_pct);
            if (p == start_at) start = 1'b1;
            if (khold && p == 20) chk("k_ready_in_stream", k_ready, 0);
            offers++;
            if (pix_ready) hits++;
            push_p(img[p / W][p % W]);
            start = 1'b0;
        end
        k_valid = 1'b0;

        n = 0;
        while (done_cnt == d0 && n < 200) begin @(negedge clk); n++; end
        if (done_cnt == d0) fail("done_timeout", n);
        repeat (8) @(negedge clk);
        chk("done_count", done_cnt - d0, 1);
        chk("vout_count", vout_seen - v0, (H-3)*(W-3));
        chk("pix_ready_stream", hits, offers);
        chk("busy_after_frame", busy, 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; k_valid = 1'b0; k_data = '0;
        pix_valid = 1'b0; pix_data = '0;
        repeat (3) @(negedge clk);
        chk("reset_data", {data_out0, data_out1, data_out2, data_out3}, '0);
        chk("reset_strobes", {kernel_load, valid_in, valid_out, done, busy}, '0);
        chk("reset_ready", {k_ready, pix_ready}, '0);
        chk("reset_coords", {out_row, out_col}, '0);
        rst = 1'b0;
        @(negedge clk);

        run_frame(1'b0,  0, -1, 1'b0, -1);
        run_frame(1'b0, 50, -1, 1'b0, -1);
        run_frame(1'b0, 20, 10, 1'b0, -1);
        run_frame(1'b1, 30, -1, 1'b1, -1);
        run_frame(1'b0,  0, -1, 1'b0, 4*W + 2);
        run_frame(1'b0,  0, -1, 1'b0, -1);
        run_frame(1'b1, 50, -1, 1'b0, -1);

        chk("final_vin_queue", vin_exp.size(), 0);
        chk("final_vout_queue", vout_exp.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end
endmodule
